// File: rtl/alu_writeback_pkg.sv
// rtl/alu_writeback_pkg.sv - shared opcodes, flag indices, condition codes and FSM states
package alu_writeback_pkg;

  // ALU operation codes as presented on ALUX
  localparam logic [3:0] ALU_MOV = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_NOT = 4'b0110;
  localparam logic [3:0] ALU_SL  = 4'b0111;
  localparam logic [3:0] ALU_SR  = 4'b1000;
  localparam logic [3:0] ALU_ASR = 4'b1001;
  localparam logic [3:0] ALU_ROL = 4'b1010;
  localparam logic [3:0] ALU_ROR = 4'b1011;
  localparam logic [3:0] ALU_INC = 4'b1100;
  localparam logic [3:0] ALU_DEC = 4'b1101;
  localparam logic [3:0] ALU_CMP = 4'b1110;
  localparam logic [3:0] ALU_SEX = 4'b1111;

  // Architectural flag layout {P,S,C,Z}
  localparam int FLAGS_W = 4;
  localparam int FLAG_Z  = 0;
  localparam int FLAG_C  = 1;
  localparam int FLAG_S  = 2;
  localparam int FLAG_P  = 3;

  // Condition select encodings
  localparam logic [2:0] CC_ALWAYS = 3'b000;
  localparam logic [2:0] CC_Z      = 3'b001;
  localparam logic [2:0] CC_NZ     = 3'b010;
  localparam logic [2:0] CC_C      = 3'b011;
  localparam logic [2:0] CC_NC     = 3'b100;
  localparam logic [2:0] CC_S      = 3'b101;
  localparam logic [2:0] CC_NS     = 3'b110;
  localparam logic [2:0] CC_P      = 3'b111;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

  // Only the add/subtract/shift-left family produces a meaningful carry
  function automatic logic op_writes_carry(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SL);
  endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// rtl/alu_cond_eval.sv - combinational condition-code evaluator shared with the branch unit
module alu_cond_eval
  import alu_writeback_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [2:0] sel_i,
  output logic       true_o
);

  // Select the requested flag test
  always_comb begin
    true_o = 1'b0;
    case (sel_i)
      CC_ALWAYS: true_o = 1'b1;
      CC_Z:      true_o = flags_i[FLAG_Z];
      CC_NZ:     true_o = ~flags_i[FLAG_Z];
      CC_C:      true_o = flags_i[FLAG_C];
      CC_NC:     true_o = ~flags_i[FLAG_C];
      CC_S:      true_o = flags_i[FLAG_S];
      CC_NS:     true_o = ~flags_i[FLAG_S];
      CC_P:      true_o = flags_i[FLAG_P];
      default:   true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result write-back register, flags, shadow flags and condition codes
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [3:0]            alux_i,
  input  logic [DATA_W-1:0]     result_i,
  input  logic                  sign_i,
  input  logic                  carry_i,
  input  logic                  zero_i,
  input  logic                  parity_i,
  input  logic [REG_ADDR_W-1:0] dest_i,
  input  logic                  flags_en_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic [REG_ADDR_W-1:0] wb_addr_o,
  output logic [3:0]            flags_o,
  input  logic                  flags_save_i,
  input  logic                  flags_restore_i,
  input  logic                  cc_req_i,
  input  logic [2:0]            cc_sel_i,
  output logic                  cc_valid_o,
  output logic                  cc_true_o
);

  wb_state_e             state_q;
  logic [DATA_W-1:0]     wb_data_q;
  logic [REG_ADDR_W-1:0] wb_addr_q;
  logic [FLAGS_W-1:0]    flags_q, flags_d;
  logic [FLAGS_W-1:0]    shadow_q, shadow_d;
  logic                  cc_valid_q, cc_true_q;
  logic                  cc_eval;
  logic                  accept;
  logic                  is_cmp;

  // A full entry can be refilled in the same cycle the register file drains it
  assign alu_ready_o = (state_q == WB_EMPTY) | wb_ready_i;
  assign accept      = alu_valid_i & alu_ready_o;
  assign is_cmp      = (alux_i == ALU_CMP);

  // Write-back entry FSM; compares update flags only and never occupy the entry
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= WB_EMPTY;
      wb_data_q <= '0;
      wb_addr_q <= '0;
    end else begin
      case (state_q)
        WB_EMPTY: begin
          if (accept && !is_cmp) begin
            state_q   <= WB_FULL;
            wb_data_q <= result_i;
            wb_addr_q <= dest_i;
          end
        end
        WB_FULL: begin
          if (accept && !is_cmp) begin
            wb_data_q <= result_i;
            wb_addr_q <= dest_i;
          end else if (wb_ready_i) begin
            state_q <= WB_EMPTY;
          end
        end
        default: state_q <= WB_EMPTY;
      endcase
    end
  end

  // Next flags: ALU update, then restore overrides; save always sees the pre-edge flags
  always_comb begin
    flags_d  = flags_q;
    shadow_d = shadow_q;
    if (accept && flags_en_i) begin
      flags_d[FLAG_Z] = zero_i;
      flags_d[FLAG_S] = sign_i;
      flags_d[FLAG_P] = parity_i;
      if (op_writes_carry(alux_i)) begin
        flags_d[FLAG_C] = carry_i;
      end
    end
    if (flags_restore_i) begin
      flags_d = shadow_q;
    end
    if (flags_save_i) begin
      shadow_d = flags_q;
    end
  end

  // Conditions are evaluated on the bypassed next flags so a same-cycle compare is visible
  alu_cond_eval u_cond_eval (
    .flags_i (flags_d),
    .sel_i   (cc_sel_i),
    .true_o  (cc_eval)
  );

  // Flag, shadow and condition-result registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flags_q    <= '0;
      shadow_q   <= '0;
      cc_valid_q <= 1'b0;
      cc_true_q  <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      shadow_q   <= shadow_d;
      cc_valid_q <= cc_req_i;
      if (cc_req_i) begin
        cc_true_q <= cc_eval;
      end
    end
  end

  assign wb_valid_o = (state_q == WB_FULL);
  assign wb_data_o  = wb_data_q;
  assign wb_addr_o  = wb_addr_q;
  assign flags_o    = flags_q;
  assign cc_valid_o = cc_valid_q;
  assign cc_true_o  = cc_true_q;

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - scoreboard bench for alu_writeback against a flag/queue reference model
module tb_alu_writeback;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [3:0]  alux_i;
  logic [15:0] result_i;
  logic        sign_i, carry_i, zero_i, parity_i;
  logic [3:0]  dest_i;
  logic        flags_en_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [15:0] wb_data_o;
  logic [3:0]  wb_addr_o;
  logic [3:0]  flags_o;
  logic        flags_save_i, flags_restore_i;
  logic        cc_req_i;
  logic [2:0]  cc_sel_i;
  logic        cc_valid_o, cc_true_o;

  alu_writeback #(.DATA_W(16), .REG_ADDR_W(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alux_i(alux_i), .result_i(result_i),
    .sign_i(sign_i), .carry_i(carry_i), .zero_i(zero_i), .parity_i(parity_i),
    .dest_i(dest_i), .flags_en_i(flags_en_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_data_o(wb_data_o), .wb_addr_o(wb_addr_o),
    .flags_o(flags_o),
    .flags_save_i(flags_save_i), .flags_restore_i(flags_restore_i),
    .cc_req_i(cc_req_i), .cc_sel_i(cc_sel_i),
    .cc_valid_o(cc_valid_o), .cc_true_o(cc_true_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  bit done  = 0;

  // Expected write-back entries {addr, data} in issue order
  logic [19:0] exp_q[$];
  logic [3:0]  m_flags, m_shadow;
  logic        m_ccv, m_cct;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic cond(input logic [3:0] f, input logic [2:0] sel);
    logic zf, cf, sf, pf;
    zf = f[0]; cf = f[1]; sf = f[2]; pf = f[3];
    case (sel)
      3'd0: return 1'b1;
      3'd1: return zf;
      3'd2: return !zf;
      3'd3: return cf;
      3'd4: return !cf;
      3'd5: return sf;
      3'd6: return !sf;
      default: return pf;
    endcase
  endfunction

  // One cycle of stimulus; called at posedge+1, returns at the following posedge+1
  task automatic step(input logic v, input logic [3:0] op, input logic [15:0] res,
                      input logic s, input logic c, input logic z, input logic p,
                      input logic [3:0] dst, input logic fen, input logic wr,
                      input logic sv, input logic rs, input logic ccr, input logic [2:0] ccs);
    logic       ready, acc;
    logic [3:0] nf;
    alu_valid_i = v; alux_i = op; result_i = res;
    sign_i = s; carry_i = c; zero_i = z; parity_i = p;
    dest_i = dst; flags_en_i = fen; wb_ready_i = wr;
    flags_save_i = sv; flags_restore_i = rs; cc_req_i = ccr; cc_sel_i = ccs;
    #1;
    ready = (exp_q.size() == 0) || wr;
    chk("alu_ready", alu_ready_o, ready);
    acc = v && ready;
    nf = m_flags;
    if (acc && fen) begin
      nf[0] = z; nf[2] = s; nf[3] = p;
      if (op == 4'd1 || op == 4'd2 || op == 4'd7) nf[1] = c;
    end
    if (rs) nf = m_shadow;
    if (sv) m_shadow = m_flags;
    m_flags = nf;
    m_ccv = ccr;
    if (ccr) m_cct = cond(nf, ccs);
    if (acc && op != 4'hE) exp_q.push_back({dst, res});
    @(posedge clk_i); #1;
    chk("flags", flags_o, m_flags);
    chk("cc_valid", cc_valid_o, m_ccv);
    chk("cc_true", cc_true_o, m_cct);
    chk("wb_valid", wb_valid_o, exp_q.size() != 0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1; alu_valid_i = 0; wb_ready_i = 0; cc_req_i = 0;
    flags_save_i = 0; flags_restore_i = 0;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    exp_q.delete();
    m_flags = 0; m_shadow = 0; m_ccv = 0; m_cct = 0;
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_wb_addr", wb_addr_o, 0);
    chk("rst_flags", flags_o, 0);
    chk("rst_cc_valid", cc_valid_o, 0);
    chk("rst_cc_true", cc_true_o, 0);
  endtask

  task automatic idle(input logic wr);
    step(0, 4'h0, 16'h0, 0, 0, 0, 0, 4'h0, 0, wr, 0, 0, 0, 3'd0);
  endtask

  // Monitor: every handshake on the write-back port must match the oldest expected entry
  initial begin
    logic [19:0] e;
    while (!done) begin
      @(negedge clk_i);
      if (!reset_i && wb_valid_o && wb_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wb_addr", wb_addr_o, e[19:16]);
          chk("wb_data", wb_data_o, e[15:0]);
        end
      end
    end
  end

  initial begin
    reset_i = 1; alu_valid_i = 0; alux_i = 0; result_i = 0;
    sign_i = 0; carry_i = 0; zero_i = 0; parity_i = 0; dest_i = 0;
    flags_en_i = 0; wb_ready_i = 0; flags_save_i = 0; flags_restore_i = 0;
    cc_req_i = 0; cc_sel_i = 0;
    @(posedge clk_i); #1;
    do_reset();

    // ADD with zero and carry, immediately written back
    step(1, 4'h1, 16'h0000, 0, 1, 1, 0, 4'd3, 1, 1, 0, 0, 0, 3'd0);
    chk("tp_add_flags", flags_o, 4'b0011);
    chk("tp_add_addr", wb_addr_o, 3);
    idle(1);

    // CMP with same-cycle branch on Z
    step(1, 4'hE, 16'h1234, 0, 0, 1, 0, 4'd7, 1, 1, 0, 0, 1, 3'd1);
    chk("tp_cmp_z", flags_o[0], 1);
    chk("tp_cmp_ccv", cc_valid_o, 1);
    chk("tp_cmp_cct", cc_true_o, 1);
    chk("tp_cmp_nowb", wb_valid_o, 0);

    // Backpressure: BEEF held while the register file stalls
    step(1, 4'h0, 16'hBEEF, 0, 0, 0, 0, 4'd5, 0, 1, 0, 0, 0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'h0, 16'h1234, 0, 0, 0, 0, 4'd6, 0, 0, 0, 0, 0, 3'd0);
      chk("tp_hold_data", wb_data_o, 16'hBEEF);
    end
    step(1, 4'h0, 16'h1234, 0, 0, 0, 0, 4'd6, 0, 1, 0, 0, 0, 3'd0);
    chk("tp_refill_data", wb_data_o, 16'h1234);
    idle(1);

    // SUB clears C, then OR with carry set leaves C alone
    step(1, 4'h2, 16'h0001, 0, 0, 0, 0, 4'd1, 1, 1, 0, 0, 0, 3'd0);
    step(1, 4'h4, 16'h8001, 1, 1, 0, 1, 4'd1, 1, 1, 0, 0, 0, 3'd0);
    chk("tp_or_flags", flags_o, 4'b1100);

    // Save 0101, CMP overwrites, restore wins over a same-cycle update
    step(1, 4'h0, 16'h0000, 1, 0, 1, 0, 4'd2, 1, 1, 0, 0, 0, 3'd0);
    chk("tp_pre_save", flags_o, 4'b0101);
    step(0, 4'h0, 16'h0000, 0, 0, 0, 0, 4'd0, 0, 1, 1, 0, 0, 3'd0);
    step(1, 4'hE, 16'h0000, 0, 0, 1, 0, 4'd0, 1, 1, 0, 0, 0, 3'd0);
    chk("tp_cmp_flags", flags_o, 4'b0001);
    step(1, 4'h0, 16'hAAAA, 1, 1, 0, 1, 4'd4, 1, 1, 0, 1, 0, 3'd0);
    chk("tp_restore", flags_o, 4'b0101);
    idle(1);

    // Reset while FULL discards the entry
    step(1, 4'h0, 16'h5A5A, 0, 0, 0, 0, 4'd9, 1, 0, 0, 0, 0, 3'd0);
    do_reset();
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), 4'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom), 3'($urandom));
    end
    for (int i = 0; i < 3; i++) idle(1);
    chk("drained", exp_q.size(), 0);

    done = 1;
    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
